// File: rtl/mmu_hs_if.sv
// mmu_hs_if: bundle of the instruction, data and I/O port signals of mmu_hs.
// The slave modport is the MMU's view; the master modport is the environment's
// view (core, ROM and I/O bank).
interface mmu_hs_if;
  // Instruction side
  logic [31:0] im_addr;
  logic [9:0]  im_addr_out;
  logic [31:0] im_data;
  logic [31:0] im_do;
  // Data request/response side
  logic        dm_req;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic        is_signed;
  logic [31:0] dm_di;
  logic        dm_rvalid;
  logic [31:0] dm_do;
  logic [1:0]  dm_fault;
  // I/O bank side
  logic        io_en;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_data_write;
  logic        io_ack;
  logic [31:0] io_data_read;

  modport slave (
    input  im_addr, im_data,
    input  dm_req, dm_we, dm_addr, dm_be, is_signed, dm_di,
    input  io_ack, io_data_read,
    output im_addr_out, im_do,
    output dm_ready, dm_rvalid, dm_do, dm_fault,
    output io_en, io_we, io_addr, io_data_write
  );

  modport master (
    output im_addr, im_data,
    output dm_req, dm_we, dm_addr, dm_be, is_signed, dm_di,
    output io_ack, io_data_read,
    input  im_addr_out, im_do,
    input  dm_ready, dm_rvalid, dm_do, dm_fault,
    input  io_en, io_we, io_addr, io_data_write
  );
endinterface

// File: rtl/mmu_hs.sv
// mmu_hs: data/instruction MMU with request/ready handshake, four byte-lane
// RAM banks, a handshaked variable-latency I/O port and fault reporting.
// Optional feature: define MMU_IO_TIMEOUT_EN to abort I/O accesses that are
// not acknowledged within IO_TIMEOUT cycles (fault 11).
module mmu_hs #(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_WORDS_LOG = 8,
  parameter int IO_TIMEOUT    = 15
) (
  input  logic         clk,
  input  logic         resetb,
  mmu_hs_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_IO_WAIT, S_IO_RESP} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_IO} src_t;

  localparam logic [1:0] F_OK      = 2'b00;
  localparam logic [1:0] F_ALIGN   = 2'b01;
  localparam logic [1:0] F_UNMAP   = 2'b10;
  localparam logic [1:0] F_TIMEOUT = 2'b11;

  state_t      r_state, w_state_nxt;
  logic        r_rvalid, w_rvalid_nxt;
  logic [1:0]  r_fault, w_fault_nxt;
  src_t        r_src, w_src_nxt;
  logic [1:0]  r_shift;
  logic [3:0]  r_be;
  logic        r_signed;
  logic        r_io_en, w_io_en_nxt;
  logic        r_io_we;
  logic [7:0]  r_io_addr;
  logic [31:0] r_io_wdata;
  logic [31:0] r_io_rdata;
  logic [31:0] r_im_do;

  logic        w_ctx_load, w_io_start, w_io_capture;
  logic        w_accept, w_be_ok, w_is_ram, w_is_io, w_timeout;
  logic        w_ram_we, w_ram_rd;
  logic [1:0]  w_ofs, w_fault;
  logic [31:0] w_wdata, w_bank_q, w_raw, w_shifted, w_ext, w_do;
  logic [RAM_WORDS_LOG-1:0] w_idx;
  logic        w_unused;

  assign w_unused = ^{bus.im_addr[31:12], bus.im_addr[1:0]};

  // Request decode: lane/offset legality, address region and store lane shift
  always_comb begin
    w_ofs   = bus.dm_addr[1:0];
    w_be_ok = 1'b0;
    case (bus.dm_be)
      4'b1111, 4'b0011: w_be_ok = (w_ofs == 2'd0);
      4'b1100:          w_be_ok = (w_ofs == 2'd2);
      4'b0001:          w_be_ok = (w_ofs == 2'd0);
      4'b0010:          w_be_ok = (w_ofs == 2'd1);
      4'b0100:          w_be_ok = (w_ofs == 2'd2);
      4'b1000:          w_be_ok = (w_ofs == 2'd3);
      default:          w_be_ok = 1'b0;
    endcase
    w_is_ram = (bus.dm_addr >= 32'h1000_0000) && (bus.dm_addr <= 32'h7FFF_FFFF);
    w_is_io  = (bus.dm_addr[31:8] == 24'h80_0000);
    if (!w_be_ok)                 w_fault = F_ALIGN;
    else if (!w_is_ram && !w_is_io) w_fault = F_UNMAP;
    else                          w_fault = F_OK;
    w_wdata = bus.dm_di << {w_ofs, 3'b000};
  end

  // The RAM base 0x10000000 has zero low bits, so subtracting it leaves the
  // word index bits untouched; higher bits are dropped, giving the aliasing.
  assign w_idx    = bus.dm_addr[RAM_WORDS_LOG+1:2];
  assign w_accept = bus.dm_req && (r_state == S_IDLE);
  assign w_ram_we = w_accept && w_is_ram && w_be_ok && bus.dm_we;
  assign w_ram_rd = w_accept && w_is_ram && w_be_ok && !bus.dm_we;

  // Four byte-lane banks with synchronous read, one per lane
  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0] r_mem [RAM_WORDS];
    logic [7:0] r_q;
    // Byte write on enabled lane; read word captured at the accept edge
    always_ff @(posedge clk) begin
      if (w_ram_we && bus.dm_be[k]) r_mem[w_idx] <= w_wdata[8*k +: 8];
      if (w_ram_rd)                 r_q <= r_mem[w_idx];
    end
    assign w_bank_q[8*k +: 8] = r_q;
  end

`ifdef MMU_IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(IO_TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  // Wait-cycle counter, cleared when an I/O access is launched
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                     r_cnt <= '0;
    else if (w_io_start)             r_cnt <= '0;
    else if (r_state == S_IO_WAIT)   r_cnt <= r_cnt + 1'b1;
  end
  assign w_timeout = (r_state == S_IO_WAIT) && (r_cnt == CNT_W'(IO_TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (IO_TIMEOUT == 0);
  assign w_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and response control; RAM and faults answer from IDLE directly
  always_comb begin
    w_state_nxt  = r_state;
    w_rvalid_nxt = 1'b0;
    w_fault_nxt  = r_fault;
    w_src_nxt    = r_src;
    w_io_en_nxt  = r_io_en;
    w_ctx_load   = 1'b0;
    w_io_start   = 1'b0;
    w_io_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.dm_req) begin
          w_ctx_load = 1'b1;
          if (w_fault != F_OK) begin
            w_rvalid_nxt = 1'b1;
            w_fault_nxt  = w_fault;
            w_src_nxt    = SRC_ZERO;
          end else if (w_is_io) begin
            w_state_nxt  = S_IO_WAIT;
            w_io_start   = 1'b1;
            w_io_en_nxt  = 1'b1;
            w_fault_nxt  = F_OK;
            w_src_nxt    = bus.dm_we ? SRC_ZERO : SRC_IO;
          end else begin
            w_rvalid_nxt = 1'b1;
            w_fault_nxt  = F_OK;
            w_src_nxt    = bus.dm_we ? SRC_ZERO : SRC_RAM;
          end
        end
      end
      S_IO_WAIT: begin
        if (bus.io_ack) begin
          w_io_capture = 1'b1;
          w_io_en_nxt  = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = S_IO_RESP;
        end else if (w_timeout) begin
          w_io_en_nxt  = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_fault_nxt  = F_TIMEOUT;
          w_src_nxt    = SRC_ZERO;
          w_state_nxt  = S_IO_RESP;
        end
      end
      S_IO_RESP: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Response, access context and I/O port registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rvalid   <= 1'b0;
      r_fault    <= F_OK;
      r_src      <= SRC_ZERO;
      r_shift    <= 2'd0;
      r_be       <= 4'd0;
      r_signed   <= 1'b0;
      r_io_en    <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_addr  <= 8'd0;
      r_io_wdata <= 32'd0;
      r_io_rdata <= 32'd0;
    end else begin
      r_rvalid <= w_rvalid_nxt;
      r_fault  <= w_fault_nxt;
      r_src    <= w_src_nxt;
      r_io_en  <= w_io_en_nxt;
      if (w_ctx_load) begin
        r_shift  <= bus.dm_addr[1:0];
        r_be     <= bus.dm_be;
        r_signed <= bus.is_signed;
      end
      if (w_io_start) begin
        r_io_we    <= bus.dm_we;
        r_io_addr  <= bus.dm_addr[7:0];
        r_io_wdata <= w_wdata;
      end
      if (w_io_capture) r_io_rdata <= bus.io_data_read;
    end
  end

  // Instruction word register, NOP out of reset
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_im_do <= 32'h0000_0013;
    else         r_im_do <= bus.im_data;
  end

  // Load formatting: right-justify selected lanes, then zero/sign extend
  always_comb begin
    w_raw     = (r_src == SRC_IO) ? r_io_rdata : w_bank_q;
    w_shifted = w_raw >> {r_shift, 3'b000};
    case (r_be)
      4'b0011, 4'b1100:
        w_ext = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        w_ext = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      default:
        w_ext = w_shifted;
    endcase
    w_do = (r_rvalid && (r_src != SRC_ZERO)) ? w_ext : 32'd0;
  end

  assign bus.im_addr_out   = bus.im_addr[11:2];
  assign bus.im_do         = r_im_do;
  assign bus.dm_ready      = (r_state == S_IDLE);
  assign bus.dm_rvalid     = r_rvalid;
  assign bus.dm_do         = w_do;
  assign bus.dm_fault      = r_fault;
  assign bus.io_en         = r_io_en;
  assign bus.io_we         = r_io_we;
  assign bus.io_addr       = r_io_addr;
  assign bus.io_data_write = r_io_wdata;

endmodule
